// File: rtl/slice_packer.sv
// slice_packer: streams one ProRes slice as bytes (6-byte header, then Y, Cb, Cr)
// read back from the component output buffer, over a valid/ready byte interface.
// Optional feature: define SLICE_PACKER_PAD_EN to append 0x00 bytes after Cr so
// that every slice is a multiple of 4 bytes long.

module slice_packer #(
  parameter int ADDR_W     = 12,
  parameter int Y_OFFSET   = 0,
  parameter int CB_OFFSET  = 2048,
  parameter int CR_OFFSET  = 3072,
  parameter int REGION_END = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        qscale,
  input  logic [31:0]       y_size,
  input  logic [31:0]       cb_size,
  input  logic [31:0]       cr_size,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [31:0]       total_size,
  output logic              size_err
);

  // Largest payload each component region can hold.
  localparam logic [31:0] Y_MAX  = 32'(CB_OFFSET - Y_OFFSET);
  localparam logic [31:0] CB_MAX = 32'(CR_OFFSET - CB_OFFSET);
  localparam logic [31:0] CR_MAX = 32'(REGION_END - CR_OFFSET);

  // First header byte encodes the header length (6 bytes) shifted left by 3.
  localparam logic [7:0] HDR_SIZE_BYTE = 8'h30;
  localparam logic [2:0] HDR_LAST      = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ST_Y,
    ST_CB,
    ST_CR,
    DRAIN,
`ifdef SLICE_PACKER_PAD_EN
    PAD,
`endif
    DONE
  } state_t;

  state_t state, state_next;

  // Latched slice parameters (already clamped to their regions).
  logic [7:0]  qscale_r;
  logic [15:0] ysz, cbsz, crsz;

  // Progress counters.
  logic [2:0]  hdr_idx;
  logic [15:0] rd_cnt;
  logic [15:0] emitted;

  // Two-entry output FIFO fed by the one-cycle-latency buffer read.
  logic [7:0]  fifo_mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  fifo_count;
  logic        inflight;

  // Combinational helpers.
  logic              accept_start;
  logic [15:0]       cur_size;
  logic [ADDR_W-1:0] cur_base;
  logic [7:0]        hdr_byte;
  logic              from_fifo;
  logic              xfer;
  logic              fifo_pop;
  logic [1:0]        fifo_credit;
  logic              rd_issue;
  logic              comp_last;

  assign accept_start = start && (state == IDLE);
  assign xfer         = out_valid && out_ready;
  assign fifo_pop     = xfer && from_fifo;

  // Occupancy the FIFO will have once this cycle's pop and the returning read settle;
  // counting the pop lets a new read go out every cycle while the consumer keeps up.
  assign fifo_credit  = fifo_count + 2'(inflight) - 2'(fifo_pop);

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  // Select the size and base address of the component currently being read.
  always_comb begin
    cur_size = 16'd0;
    cur_base = '0;
    case (state)
      ST_Y: begin
        cur_size = ysz;
        cur_base = ADDR_W'(Y_OFFSET);
      end
      ST_CB: begin
        cur_size = cbsz;
        cur_base = ADDR_W'(CB_OFFSET);
      end
      ST_CR: begin
        cur_size = crsz;
        cur_base = ADDR_W'(CR_OFFSET);
      end
      default: begin
        cur_size = 16'd0;
        cur_base = '0;
      end
    endcase
  end

  // Read issue: only in a component state with bytes left and FIFO room guaranteed.
  always_comb begin
    rd_issue    = 1'b0;
    mem_rd_addr = '0;
    if ((state == ST_Y || state == ST_CB || state == ST_CR) &&
        (rd_cnt < cur_size) && (fifo_credit < 2'd2)) begin
      rd_issue    = 1'b1;
      mem_rd_addr = cur_base + rd_cnt[ADDR_W-1:0];
    end
  end

  assign mem_rd_en = rd_issue;

  // A component is finished when it is empty or its final read goes out this cycle.
  assign comp_last = (cur_size == 16'd0) || (rd_issue && (rd_cnt + 16'd1 == cur_size));

  // Header byte selected by position, taken straight from the latched registers.
  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      3'd0:    hdr_byte = HDR_SIZE_BYTE;
      3'd1:    hdr_byte = qscale_r;
      3'd2:    hdr_byte = ysz[15:8];
      3'd3:    hdr_byte = ysz[7:0];
      3'd4:    hdr_byte = cbsz[15:8];
      3'd5:    hdr_byte = cbsz[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  // Output byte source: header register, pad zero, or FIFO head.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    from_fifo = 1'b0;
    case (state)
      HDR: begin
        out_valid = 1'b1;
        out_data  = hdr_byte;
      end
`ifdef SLICE_PACKER_PAD_EN
      PAD: begin
        out_valid = 1'b1;
        out_data  = 8'h00;
      end
`endif
      default: begin
        if (fifo_count != 2'd0) begin
          out_valid = 1'b1;
          out_data  = fifo_mem[rd_ptr];
          from_fifo = 1'b1;
        end
      end
    endcase
  end

  // Next-state logic for the slice sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = HDR;
      HDR:   if (xfer && (hdr_idx == HDR_LAST)) state_next = ST_Y;
      ST_Y:  if (comp_last) state_next = ST_CB;
      ST_CB: if (comp_last) state_next = ST_CR;
      ST_CR: if (comp_last) state_next = DRAIN;
      DRAIN: begin
        if ((fifo_count == 2'd0) && !inflight) begin
          state_next = DONE;
`ifdef SLICE_PACKER_PAD_EN
          if (emitted[1:0] != 2'd0) state_next = PAD;
`endif
        end
      end
`ifdef SLICE_PACKER_PAD_EN
      PAD:   if (xfer && (emitted[1:0] == 2'd3)) state_next = DONE;
`endif
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Latch header fields and clamped sizes on an accepted start; flag any clamp.
  always_ff @(posedge clock) begin
    if (reset) begin
      qscale_r <= 8'h00;
      ysz      <= 16'd0;
      cbsz     <= 16'd0;
      crsz     <= 16'd0;
      size_err <= 1'b0;
    end else if (accept_start) begin
      qscale_r <= qscale;
      ysz      <= (y_size  > Y_MAX)  ? Y_MAX[15:0]  : y_size[15:0];
      cbsz     <= (cb_size > CB_MAX) ? CB_MAX[15:0] : cb_size[15:0];
      crsz     <= (cr_size > CR_MAX) ? CR_MAX[15:0] : cr_size[15:0];
      size_err <= (y_size > Y_MAX) || (cb_size > CB_MAX) || (cr_size > CR_MAX);
    end
  end

  // Header position, per-component read count and emitted byte count.
  always_ff @(posedge clock) begin
    if (reset) begin
      hdr_idx <= 3'd0;
      rd_cnt  <= 16'd0;
      emitted <= 16'd0;
    end else if (accept_start) begin
      hdr_idx <= 3'd0;
      rd_cnt  <= 16'd0;
      emitted <= 16'd0;
    end else begin
      if (xfer) emitted <= emitted + 16'd1;
      if ((state == HDR) && xfer) hdr_idx <= hdr_idx + 3'd1;
      if (state_next != state) rd_cnt <= 16'd0;
      else if (rd_issue)       rd_cnt <= rd_cnt + 16'd1;
    end
  end

  // Read pipeline and FIFO; reset drops both stored and in-flight bytes.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      inflight <= rd_issue;
      if (inflight) begin
        fifo_mem[wr_ptr] <= mem_rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (fifo_pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + 2'(inflight) - 2'(fifo_pop);
    end
  end

  // Publish the final byte count as DONE is entered so it is valid alongside done.
  always_ff @(posedge clock) begin
    if (reset) begin
      total_size <= 32'd0;
    end else if ((state_next == DONE) && (state != DONE)) begin
      total_size <= {16'd0, emitted + 16'(xfer)};
    end
  end

endmodule

// File: tb/tb_slice_packer.sv
// tb_slice_packer: randomized self-checking bench for slice_packer. A behavioural
// model builds the expected byte stream and read-address list from the sizes,
// clamping rules and buffer contents; the bench compares every transfer against it.

module tb_slice_packer;

  localparam int ADDR_W = 12;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        qscale;
  logic [31:0]       y_size, cb_size, cr_size;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [7:0]        mem_rd_data;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic [31:0]       total_size;
  logic              size_err;

  int total_checks = 0;
  int bad_checks   = 0;

  logic [7:0] mem [4096];
  logic [7:0] byte_q [$];
  int         addr_q [$];
  int         issued, accepted, ready_pct, exp_total;
  logic       exp_err;
  bit         mon_en, prev_stall, found_flag;
  logic [7:0] prev_data;

  slice_packer #(
    .ADDR_W(ADDR_W), .Y_OFFSET(0), .CB_OFFSET(2048), .CR_OFFSET(3072), .REGION_END(4096)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .qscale(qscale),
    .y_size(y_size), .cb_size(cb_size), .cr_size(cr_size),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .total_size(total_size), .size_err(size_err)
  );

  always #5 clock = ~clock;

  // Buffer model: read data appears one cycle after the strobe.
  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-cycle stream observation, sampled mid-cycle.
  task automatic monitorCycle();
    int payload;
    if (prev_stall) begin
      if (!out_valid) checkOutput("valid_held", 32'(out_valid), 32'd1);
      else            checkOutput("data_held", 32'(out_data), 32'(prev_data));
    end
    if (mem_rd_en) begin
      issued++;
      if (addr_q.size() == 0) checkOutput("rd_addr_extra", 32'(mem_rd_addr), 32'hFFFFFFFF);
      else                    checkOutput("rd_addr", 32'(mem_rd_addr), 32'(addr_q.pop_front()));
    end
    if (out_valid && out_ready) begin
      accepted++;
      if (byte_q.size() == 0) checkOutput("byte_extra", 32'(out_data), 32'hFFFFFFFF);
      else                    checkOutput("out_byte", 32'(out_data), 32'(byte_q.pop_front()));
    end
    payload = (accepted > 6) ? accepted - 6 : 0;
    checkOutput("outstanding_le2", 32'((issued - payload) <= 2), 32'd1);
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  endtask

  task automatic step(input logic st);
    @(posedge clock);
    #1;
    start     = st;
    out_ready = ($urandom_range(0, 99) < ready_pct);
    @(negedge clock);
    if (mon_en) monitorCycle();
  endtask

  // Reference model: expected bytes and read addresses from the slice rules.
  task automatic buildExpected(input logic [7:0] qs, input logic [31:0] ys,
                               input logic [31:0] cbs, input logic [31:0] crs);
    int yc, cbc, crc;
    yc  = (ys  > 32'd2048) ? 2048 : int'(ys);
    cbc = (cbs > 32'd1024) ? 1024 : int'(cbs);
    crc = (crs > 32'd1024) ? 1024 : int'(crs);
    exp_err = (ys > 32'd2048) || (cbs > 32'd1024) || (crs > 32'd1024);
    byte_q.delete();
    addr_q.delete();
    byte_q.push_back(8'h30);
    byte_q.push_back(qs);
    byte_q.push_back(8'(yc >> 8));
    byte_q.push_back(8'(yc));
    byte_q.push_back(8'(cbc >> 8));
    byte_q.push_back(8'(cbc));
    for (int i = 0; i < yc; i++)  begin addr_q.push_back(i);        byte_q.push_back(mem[i]);        end
    for (int i = 0; i < cbc; i++) begin addr_q.push_back(2048 + i); byte_q.push_back(mem[2048 + i]); end
    for (int i = 0; i < crc; i++) begin addr_q.push_back(3072 + i); byte_q.push_back(mem[3072 + i]); end
    exp_total = 6 + yc + cbc + crc;
`ifdef SLICE_PACKER_PAD_EN
    while ((exp_total % 4) != 0) begin
      byte_q.push_back(8'h00);
      exp_total++;
    end
`endif
    issued     = 0;
    accepted   = 0;
    prev_stall = 1'b0;
  endtask

  // Run one slice; busy_at >= 1 pulses a spurious start that cycle while busy.
  task automatic applyStimulus(input logic [7:0] qs, input logic [31:0] ys,
                               input logic [31:0] cbs, input logic [31:0] crs,
                               input int pct, input int busy_at);
    bit found;
    buildExpected(qs, ys, cbs, crs);
    ready_pct = pct;
    mon_en    = 1'b1;
    qscale    = qs;
    y_size    = ys;
    cb_size   = cbs;
    cr_size   = crs;
    step(1'b1);
    found = 1'b0;
    for (int cyc = 0; cyc < 12000; cyc++) begin
      if (cyc == busy_at) begin
        qscale  = 8'hA5;
        y_size  = 32'd9;
        cb_size = 32'd0;
        cr_size = 32'd0;
      end
      step(cyc == busy_at);
      if (cyc == 0) checkOutput("busy_after_start", 32'(busy), 32'd1);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("total_size", total_size, 32'(exp_total));
      checkOutput("size_err", 32'(size_err), 32'(exp_err));
      checkOutput("busy_at_done", 32'(busy), 32'd0);
      checkOutput("bytes_left", 32'(byte_q.size()), 32'd0);
      checkOutput("reads_left", 32'(addr_q.size()), 32'd0);
    end
    // A start presented during the done cycle must be ignored.
    qscale  = 8'h5A;
    y_size  = 32'd3;
    cb_size = 32'd1;
    cr_size = 32'd1;
    start   = 1'b1;
    step(1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_valid", 32'(out_valid), 32'd0);
    end
    checkOutput("total_size_hold", total_size, 32'(exp_total));
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    qscale    = 8'h00;
    y_size    = 32'd0;
    cb_size   = 32'd0;
    cr_size   = 32'd0;
    out_ready = 1'b0;
    ready_pct = 100;
    mon_en    = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i);

    repeat (3) step(1'b0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_rd_en", 32'(mem_rd_en), 32'd0);
    checkOutput("rst_total", total_size, 32'd0);
    checkOutput("rst_size_err", 32'(size_err), 32'd0);
    reset = 1'b0;
    step(1'b0);

    $display("[TB] basic slice");
    applyStimulus(8'h04, 32'd3, 32'd2, 32'd1, 100, -1);

    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

    $display("[TB] backpressure");
    applyStimulus(8'h11, 32'd8, 32'd4, 32'd4, 50, -1);

    $display("[TB] zero-size components");
    applyStimulus(8'h22, 32'd5, 32'd0, 32'd0, 70, -1);

    $display("[TB] clamp then legal slice with start while busy");
    applyStimulus(8'h33, 32'd5000, 32'd3, 32'd2, 100, -1);
    applyStimulus(8'h34, 32'd10, 32'd6, 32'd3, 60, 3);
    applyStimulus(8'h35, 32'd2049, 32'd70000, 32'd1025, 85, -1);

    $display("[TB] reset during Cb payload");
    buildExpected(8'h44, 32'd40, 32'd40, 32'd8);
    ready_pct  = 100;
    mon_en     = 1'b1;
    qscale     = 8'h44;
    y_size     = 32'd40;
    cb_size    = 32'd40;
    cr_size    = 32'd8;
    step(1'b1);
    found_flag = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      step(1'b0);
      if (mem_rd_en && (mem_rd_addr >= 12'd2048) && (mem_rd_addr < 12'd3072)) begin
        found_flag = 1'b1;
        break;
      end
    end
    checkOutput("reached_cb", 32'(found_flag), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_rd_en", 32'(mem_rd_en), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b0;
    applyStimulus(8'h45, 32'd40, 32'd40, 32'd8, 75, -1);

    $display("[TB] random slices");
    for (int n = 0; n < 6; n++) begin
      applyStimulus(8'($urandom), 32'($urandom_range(0, 40)), 32'($urandom_range(0, 40)),
                    32'($urandom_range(0, 40)), int'($urandom_range(30, 100)),
                    int'($urandom_range(2, 20)));
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/slice_packer.md
Name: slice_packer

Overview:
Reads the three entropy-coded component bitstreams (Y, Cb, Cr) back out of the slice output buffer once the slice sequencer has finished. Emits one complete ProRes slice as a byte stream with valid/ready handshake: a 6-byte slice header, then Y, Cb and Cr payloads, back to back. Sits between the component output memory and the frame/bitstream assembler. Consumes the captured y/cb sizes plus the Cr size.

Parameters:
ADDR_W, 12, byte address width of the component output buffer
Y_OFFSET, 0, byte base address of the Y payload
CB_OFFSET, 2048, byte base address of the Cb payload
CR_OFFSET, 3072, byte base address of the Cr payload
REGION_END, 4096, first address past the Cr region

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: begin packing one slice
qscale  in  8  quantiser scale for the header
y_size  in  32  Y payload bytes
cb_size  in  32  Cb payload bytes
cr_size  in  32  Cr payload bytes
mem_rd_en  out  1  buffer read strobe
mem_rd_addr  out  ADDR_W  buffer byte address
mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en
out_data  out  8  stream byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts byte when out_valid&&out_ready
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last byte transferred
total_size  out  32  bytes emitted for the last slice, valid from done
size_err  out  1  sticky per slice: a size was clamped

Behaviour:
- Reset (synchronous, clock edge with reset=1, any state, including mid-slice): state IDLE; all outputs 0. Internal FIFO is flushed; any in-flight read data is discarded.
- start in IDLE: latch qscale and sizes, then go to HDR; busy=1 next cycle. start while busy is ignored.
- Clamp at latch:
  - y_size to CB_OFFSET-Y_OFFSET (2048).
  - cb_size to CR_OFFSET-CB_OFFSET (1024).
  - cr_size to REGION_END-CR_OFFSET (1024).
  - Any clamp sets size_err for this slice; size_err is cleared at the next accepted start.
- HDR state: emits 6 bytes in order: 0x30 (header size 6<<3), qscale, ysz[15:8], ysz[7:0], cbsz[15:8], cbsz[7:0]. Clamped values are used. Header bytes come directly from registers, with no memory read.
- States Y, CB, CR: issue reads at base+0 .. base+size-1, then go to the next state. A zero-size component issues no reads and is skipped in one cycle.
- After CR: go to DRAIN until the FIFO is empty and the last byte is transferred, then DONE. DONE lasts one cycle: done=1, busy=0, then back to IDLE.
- Read path:
  - 1-cycle memory latency feeds a 2-entry output FIFO.
  - mem_rd_en is issued only if (FIFO occupancy + reads in flight) < 2. This guarantees no overflow under arbitrary out_ready stalls.
  - Sustained throughput is 1 byte/cycle when out_ready is held high.
- Stream rules:
  - out_data/out_valid come from the FIFO head, or the header register in HDR.
  - Once asserted, out_valid and out_data stay stable until accepted.
  - Output bytes are strictly ordered: header, Y, Cb, Cr.
- total_size = 6 + ysz + cbsz + crsz (clamped values, plus pad when the optional feature is on). Updated on the done cycle and held until the next done.
- start arriving in the same cycle as done is ignored. It is accepted only from IDLE.

Optional Feature:
SLICE_PACKER_PAD_EN:
- Defined: after Cr, a PAD state appends 0x00 bytes until total bytes emitted % 4 == 0. These bytes use the normal handshake, and total_size includes them.
- Undefined: no PAD state; total_size is the exact unpadded count.

Test Plan:
- Basic slice: qscale=4, y=3, cb=2, cr=1, memory filled with address-low-byte pattern, out_ready=1 -> stream 30 04 00 03 00 02 then 00 01 02 00 01 00 (addresses 0,1,2,2048,2049,3072 low bytes); done after 12 bytes; total_size=12 (pad on: 12, already aligned).
- Backpressure: y=8, cb=4, cr=4, out_ready toggled 1-0-0-1 randomly -> byte sequence identical to the no-stall run; out_data held while stalled; never more than 2 reads outstanding.
- Zero components: y=5, cb=0, cr=0 -> header 30 qq 00 05 00 00 then 5 Y bytes; no reads at 2048/3072; total_size=11 (pad on: 12, with one 0x00 appended).
- Clamp: y_size=5000 -> header bytes 3-4 = 08 00; exactly 2048 Y bytes; size_err=1. The next slice with legal sizes -> size_err=0.
- Reset mid-slice: assert reset during Cb payload -> next cycle busy=0, out_valid=0, mem_rd_en=0. A fresh start then produces a correct full slice.
- start while busy, and start on the done cycle -> both ignored; exactly one slice emitted.
